// File: rtl/seq_divider.sv
// seq_divider: signed restoring divider with fixed N+1 cycle latency; define SEQ_DIVIDER_ZERO_CHECK_EN to flag divide-by-zero and force q=-1
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state;
  logic [N-1:0] quo, den, rem, q_fix, r_fix;
  logic [N:0] shl, dif;
  logic [CW-1:0] count;
  logic sa, sb;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic zero;
`else
  assign div_by_zero = 1'b0;
`endif
  assign shl = {rem, quo[N-1]};
  assign dif = shl - {1'b0, den};
  assign q_fix = (sa ^ sb) ? -quo : quo;
  assign r_fix = sa ? -rem : rem;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      quo <= '0;
      den <= '0;
      rem <= '0;
      count <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      done <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      zero <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          quo <= dividend[N-1] ? -dividend : dividend;
          den <= divisor[N-1] ? -divisor : divisor;
          sa <= dividend[N-1];
          sb <= divisor[N-1];
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          zero <= divisor == '0;
`endif
          rem <= '0;
          count <= CW'(N);
          state <= ITER;
        end
        ITER: begin
          rem <= dif[N] ? shl[N-1:0] : dif[N-1:0];
          quo <= {quo[N-2:0], ~dif[N]};
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          quotient <= zero ? '1 : q_fix;
          div_by_zero <= zero;
`else
          quotient <= q_fix;
`endif
          remainder <= r_fix;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and swept checks of seq_divider at N=8
module tb_seq_divider;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, start = 0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic done, busy, div_by_zero;
  int total = 0, bad = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  logic [N-1:0] va [9] = '{8'd100, -8'sd100, 8'd100, -8'sd100, -8'sd128, 8'd7, 8'd0, 8'd127, -8'sd128};
  logic [N-1:0] vb [9] = '{8'd7, 8'd7, -8'sd7, -8'sd7, -8'sd1, 8'd7, 8'd5, -8'sd128, 8'd127};
  logic [N-1:0] vq [9] = '{8'd14, -8'sd14, -8'sd14, 8'd14, -8'sd128, 8'd1, 8'd0, 8'd0, -8'sd1};
  logic [N-1:0] vr [9] = '{8'd2, -8'sd2, 8'd2, -8'sd2, 8'd0, 8'd0, 8'd0, 8'd127, -8'sd1};

  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, output logic [N-1:0] q,
                        output logic [N-1:0] r, output logic z, output int lat,
                        output logic busy1, output logic d_after, output logic b_after);
    @(negedge clk);
    dividend = a; divisor = b; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 0; busy1 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) busy1 = busy;
      if (done) begin lat = i; break; end
    end
    q = quotient; r = remainder; z = div_by_zero;
    @(posedge clk); #1;
    d_after = done; b_after = busy;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    total++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      bad++; $display("FAIL reset outputs got q=%h r=%h d=%b b=%b z=%b want all 0", quotient, remainder, done, busy, div_by_zero);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_basic;
    logic [N-1:0] q, r; logic z, b1, da, ba; int lat;
    do_div(8'd100, 8'd7, q, r, z, lat, b1, da, ba);
    total++; if (lat !== N + 1) begin bad++; $display("FAIL basic_latency got %0d want %0d", lat, N + 1); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", b1); end
    total++; if (da !== 1'b0 || ba !== 1'b0) begin bad++; $display("FAIL basic_after got done=%b busy=%b want 0 0", da, ba); end
    total++; if (q !== 8'd14 || r !== 8'd2) begin bad++; $display("FAIL basic_result got q=%0d r=%0d want 14 2", $signed(q), $signed(r)); end
  endtask

  task automatic test_signs;
    logic [N-1:0] q, r; logic z, b1, da, ba; int lat;
    for (int i = 0; i < 9; i++) begin
      do_div(va[i], vb[i], q, r, z, lat, b1, da, ba);
      total++;
      if (q !== vq[i] || r !== vr[i] || z !== 1'b0 || lat !== N + 1) begin
        bad++; $display("FAIL signs[%0d] %0d/%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=0 lat=%0d", i,
          $signed(va[i]), $signed(vb[i]), $signed(q), $signed(r), z, lat, $signed(vq[i]), $signed(vr[i]), N + 1);
      end
    end
  endtask

  task automatic test_zero;
    logic [N-1:0] q, r; logic z, b1, da, ba; int lat;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    logic [N-1:0] qn = 8'hff; logic ze = 1'b1;
`else
    logic [N-1:0] qn = 8'd1; logic ze = 1'b0;
`endif
    do_div(8'd5, 8'd0, q, r, z, lat, b1, da, ba);
    total++;
    if (q !== 8'hff || r !== 8'd5 || z !== ze || lat !== N + 1) begin
      bad++; $display("FAIL zero_pos got q=%0d r=%0d z=%b lat=%0d want q=-1 r=5 z=%b lat=%0d", $signed(q), $signed(r), z, lat, ze, N + 1);
    end
    do_div(-8'sd5, 8'd0, q, r, z, lat, b1, da, ba);
    total++;
    if (q !== qn || r !== -8'sd5 || z !== ze || lat !== N + 1) begin
      bad++; $display("FAIL zero_neg got q=%0d r=%0d z=%b lat=%0d want q=%0d r=-5 z=%b", $signed(q), $signed(r), z, lat, $signed(qn), ze);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0, at = 0;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; at = i; end
      if (i == 2) begin start = 1; dividend = 8'd50; divisor = 8'd5; end
      if (i == 8) start = 0;
    end
    total++; if (pulses !== 1 || at !== N + 1) begin bad++; $display("FAIL b2b_pulses got %0d at %0d want 1 at %0d", pulses, at, N + 1); end
    total++; if (quotient !== 8'd14 || remainder !== 8'd2) begin bad++; $display("FAIL b2b_hold got q=%0d r=%0d want 14 2", $signed(quotient), $signed(remainder)); end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] q, r; logic z, b1, da, ba; int lat, pulses = 0;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    total++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      bad++; $display("FAIL midreset_outputs got q=%h r=%h d=%b b=%b z=%b want all 0", quotient, remainder, done, busy, div_by_zero);
    end
    repeat (3) begin @(posedge clk); #1 if (done) pulses++; end
    @(negedge clk); rst_n = 1;
    repeat (12) begin @(posedge clk); #1 if (done || busy) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_nodone got %0d events want 0", pulses); end
    do_div(8'd9, 8'd3, q, r, z, lat, b1, da, ba);
    total++;
    if (q !== 8'd3 || r !== 8'd0 || lat !== N + 1) begin
      bad++; $display("FAIL midreset_after got q=%0d r=%0d lat=%0d want 3 0 %0d", $signed(q), $signed(r), lat, N + 1);
    end
  endtask

  task automatic test_sweep;
    logic [N-1:0] a, b, q, r, eq, er; logic z, b1, da, ba, ez; int lat, ai, bi, nbad = 0;
    for (int i = 0; i < 300; i++) begin
      a = N'($urandom); b = (i % 25 == 0) ? '0 : N'($urandom);
      ai = $signed(a); bi = $signed(b);
      if (bi == 0) begin
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
        eq = 8'hff; ez = 1'b1;
`else
        eq = ai < 0 ? 8'd1 : 8'hff; ez = 1'b0;
`endif
        er = a;
      end else begin
        eq = N'(ai / bi); er = N'(ai % bi); ez = 1'b0;
      end
      do_div(a, b, q, r, z, lat, b1, da, ba);
      total++;
      if (q !== eq || r !== er || z !== ez || lat !== N + 1 || da !== 1'b0) begin
        bad++; nbad++;
        if (nbad <= 5) $display("FAIL sweep %0d/%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
          ai, bi, $signed(q), $signed(r), z, lat, $signed(eq), $signed(er), ez, N + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
